multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Moore-style sequencer for the multicycle MIPS datapath.
- Replaces the single-cycle opcode decoder. Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and mux selects, and stalls on a memory-ready handshake.
- Sits between the instruction register's opcode field and the shared instruction/data memory, ALU, register file and PC.

Parameters:
- MEM_HANDSHAKE, 1: when 1, memory states wait for mem_ready; when 0, mem_ready is ignored and treated as constant 1.
- STATE_W, 4: width of the state register and of the state debug port; minimum 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  6  opcode field from the instruction register (IR[31:26])
- mem_ready  input  1  memory has completed the current read or write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register-file write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded, 11 = reserved
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  output  1  high while in HALT
- state  output  STATE_W  current state, for debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7
  - BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15
  - Encodings 12-14 are unused and go to FETCH.
- Reset: if reset=1 at a clock edge, the next state is FETCH.
  - Reset overrides every state, including HALT and memory wait states.
  - While in FETCH after reset, outputs are the FETCH values below; every output not listed for FETCH is 0.
- Output values per state. Any output not listed is 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready, so the PC and IR update only in the cycle the memory completes.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - MEMWR: mem_write=1, i_or_d=1, instr_done=mem_ready.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - JUMP: pc_write=1, pc_source=10, instr_done=1.
  - HALT: illegal_op=1.
- Transitions:
  - FETCH: to DECODE if mem_ready, else stay in FETCH.
  - DECODE, by op:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000100 (beq) -> BEQ
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> see Optional Feature
    - any other opcode -> HALT
  - MEMADR: lw -> MEMRD; sw -> MEMWR; any other op (op changed) -> HALT.
  - MEMRD: to MEMWB if mem_ready, else stay.
  - MEMWR: to FETCH if mem_ready, else stay.
  - EXEC -> ALUWB, ADDIEX -> ADDIWB.
  - ALUWB, MEMWB, BEQ, ADDIWB, JUMP -> FETCH.
  - HALT: stays in HALT until reset.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- op is sampled only in DECODE and MEMADR; it is don't-care in all other states.
- The datapath guarantees mem_read and mem_write are never high together; the FSM must preserve this.

Optional Feature:
- Macro: MULTICYCLE_JUMP_EN.
- When defined: op 000010 in DECODE goes to JUMP.
- When undefined: op 000010 is treated as illegal and goes to HALT; the JUMP state is not synthesized and its encoding goes to FETCH.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state encoding localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALU_OP_*, ALUSRCB_*, PCSRC_* encodings.
- Sub-module multicycle_ctrl_outdec: purely combinational map from (state, mem_ready) to all output signals. The top level contains only the state register and next-state logic.

Test Plan:
- Reset, then op=100011, mem_ready=1: state sequence 0,1,2,3,4,0. ir_write=1 in cycle 1 only; reg_write and mem_to_reg are 1 in cycle 5; instr_done pulses once.
- op=101011 with mem_ready held low for 2 cycles in MEMWR: MEMWR lasts 3 cycles, mem_write=1 throughout, instr_done=1 only in the third; total 6 cycles.
- op=000000, then 000100, then 001000, each with mem_ready=1: 4, 3 and 4 cycles. BEQ shows pc_write_cond=1 and pc_source=01; ALUWB shows reg_dst=1.
- op=111111: DECODE -> HALT; illegal_op=1 and all enables 0 for 10 cycles; reset=1 for one edge -> FETCH.
- Reset asserted while in MEMRD with mem_ready=0: next state is FETCH; mem_read stays 1 with i_or_d=0.
- op=000010 with MULTICYCLE_JUMP_EN defined: reaches JUMP with pc_write=1 and pc_source=10. Without the macro: reaches HALT.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
// Decode helper honours MULTICYCLE_JUMP_EN for the j opcode.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Successor of DECODE for a given opcode; unknown opcodes halt.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        nxt = S_HALT;
        case (op)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BEQ;
            OP_ADDI:      nxt = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:         nxt = S_JUMP;
`endif
            default:      nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decoder: (state, ready) to datapath controls.
// JUMP outputs exist only when MULTICYCLE_JUMP_EN is defined.
module multicycle_ctrl_outdec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    // Everything idles at 0; each state raises only what it uses.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        alu_op        = ALU_OP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: begin
                alu_src_b = ALUSRCB_IMMSH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`endif
            S_HALT: begin
                illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: state register and next state.
// Define MULTICYCLE_JUMP_EN to support the j instruction.
module multicycle_control_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    logic   ready;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state = STATE_W'(state_q);

    // State register; reset wins over any wait or halt.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state; memory states hold until ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: state_d = decode_next(op);
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_HALT;
            end
            S_MEMRD:  if (ready) state_d = S_MEMWB;
            S_MEMWR:  if (ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ,
            S_ADDIWB: state_d = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state         (state_q),
        .ready         (ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

endmodule
